// File: rtl/leb128_byte_collector.sv
// leb128_byte_collector
// Framing stage in front of the parallel LEB128 decoders. It collects the bytes
// of one LEB128 value from a valid/ready byte stream. It then presents them as
// a zero-padded 80-bit word, together with a length and an overlong flag, on a
// second valid/ready handshake.
//
// Optional feature: define LEB128_COLLECT_BYPASS_EN to let a new byte be
// accepted in the same cycle the held value is consumed. This gives one
// single-byte value per cycle. Without it, one bubble cycle separates values.
module leb128_byte_collector #(
  parameter int MAX_BYTES = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [79:0] m_bytes,
  output logic [3:0]  m_len,
  output logic        m_err,
  output logic        m_valid,
  input  logic        m_ready
);

  localparam logic [3:0] LAST_IDX = 4'(MAX_BYTES - 1);

  typedef enum logic {
    COLLECT,
    HOLD
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       accept;
  logic       xfer;
  logic       last_byte;

  // m_valid comes straight from the state register, so it is glitch-free.
  assign m_valid   = (state == HOLD);
  assign accept    = s_valid & s_ready;
  assign xfer      = m_valid & m_ready;
  // A byte ends the value if its continuation bit is clear, or if it fills the last slot.
  assign last_byte = ~s_data[7] | (cnt == LAST_IDX);

  // Input readiness: a flush blocks acceptance; HOLD accepts only in bypass builds.
  always_comb begin
    s_ready = 1'b0;
    if (!flush) begin
      case (state)
        COLLECT: s_ready = 1'b1;
`ifdef LEB128_COLLECT_BYPASS_EN
        HOLD:    s_ready = m_ready;
`else
        HOLD:    s_ready = 1'b0;
`endif
        default: s_ready = 1'b0;
      endcase
    end
  end

  // Collector FSM: byte slots, count, length/error flags and state.
  always_ff @(posedge clk) begin
    // NOTE: every register here uses non-blocking assignment. The slot loop then
    // sees the pre-edge cnt, not a value already updated earlier in this block.
    if (rst) begin
      state   <= COLLECT;
      cnt     <= '0;
      m_bytes <= '0;
      m_len   <= '0;
      m_err   <= 1'b0;
    end else if (flush) begin
      state   <= COLLECT;
      cnt     <= '0;
      m_bytes <= '0;
      m_len   <= '0;
      m_err   <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            for (int k = 0; k < 10; k++) begin
              // Slots at or above MAX_BYTES are never written and stay 0x00.
              if (k < MAX_BYTES && cnt == 4'(k)) m_bytes[8*k +: 8] <= s_data;
            end
            if (last_byte) begin
              state <= HOLD;
              m_len <= cnt + 4'd1;
              m_err <= s_data[7];
              cnt   <= '0;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        HOLD: begin
          if (xfer) begin
`ifdef LEB128_COLLECT_BYPASS_EN
            if (accept) begin
              // Release the held value and start the next value in slot 0, all in one cycle.
              m_bytes <= {72'h0, s_data};
              if (!s_data[7] || MAX_BYTES == 1) begin
                state <= HOLD;
                m_len <= 4'd1;
                m_err <= s_data[7];
                cnt   <= '0;
              end else begin
                state <= COLLECT;
                m_len <= '0;
                m_err <= 1'b0;
                cnt   <= 4'd1;
              end
            end else begin
              state   <= COLLECT;
              m_bytes <= '0;
              m_len   <= '0;
              m_err   <= 1'b0;
            end
`else
            state   <= COLLECT;
            m_bytes <= '0;
            m_len   <= '0;
            m_err   <= 1'b0;
`endif
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_leb128_byte_collector.sv
// Directed testbench for leb128_byte_collector with MAX_BYTES = 10.
// Inputs are driven 1 time unit after each rising edge, so outputs are sampled
// away from the active edge.
module tb_leb128_byte_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [79:0] m_bytes;
  logic [3:0]  m_len;
  logic        m_err;
  logic        m_valid;
  logic        m_ready;

  int n_checks = 0;
  int n_fails  = 0;

`ifdef LEB128_COLLECT_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif

  leb128_byte_collector #(.MAX_BYTES(10)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_bytes (m_bytes),
    .m_len   (m_len),
    .m_err   (m_err),
    .m_valid (m_valid),
    .m_ready (m_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte and hold it until it is accepted (bounded wait).
  task automatic send(input logic [7:0] b);
    int budget = 50;
    s_data  = b;
    s_valid = 1'b1;
    #0;
    while (!s_ready && budget > 0) begin
      tick();
      budget--;
    end
    if (!s_ready) check("send_timeout_s_ready", 80'(s_ready), 80'h1);
    tick();
    s_valid = 1'b0;
    s_data  = 8'h00;
  endtask

  // Check the full output bundle of a held value.
  task automatic check_out(input string tag, input logic [79:0] eb, input logic [3:0] el, input logic ee);
    check({tag, "_valid"}, 80'(m_valid), 80'h1);
    check({tag, "_bytes"}, m_bytes, eb);
    check({tag, "_len"},   80'(m_len), 80'(el));
    check({tag, "_err"},   80'(m_err), 80'(ee));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid0"}, 80'(m_valid), 80'h0);
    check({tag, "_bytes0"}, m_bytes, 80'h0);
    check({tag, "_len0"},   80'(m_len), 80'h0);
    check({tag, "_err0"},   80'(m_err), 80'h0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; s_data = 8'h00; s_valid = 1'b0; m_ready = 1'b0;
    tick(); tick();
    check_idle("reset");
    rst = 1'b0;
    #1;
    check("reset_s_ready", 80'(s_ready), 80'h1);

    // Single byte with m_ready high: valid for exactly one cycle.
    m_ready = 1'b1;
    send(8'h02);
    check_out("single", 80'h02, 4'd1, 1'b0);
    check("single_s_ready_hold", 80'(s_ready), 80'(BYPASS));
    tick();
    check_idle("single_after");
    m_ready = 1'b0;

    // Multi-byte value 624485.
    send(8'hE5);
    send(8'h8E);
    check("multi_mid_valid", 80'(m_valid), 80'h0);
    send(8'h26);
    check_out("multi", 80'h26_8E_E5, 4'd3, 1'b0);
    check("multi_s_ready_hold", 80'(s_ready), 80'h0);
    m_ready = 1'b1;
    tick();
    check_idle("multi_after");
    m_ready = 1'b0;

    // Overlong: ten continuation bytes, then 0x01 starts a fresh value.
    for (int i = 0; i < 10; i++) send(8'hFF);
    check_out("overlong", {10{8'hFF}}, 4'd10, 1'b1);
    m_ready = 1'b1;
    tick();
    check_idle("overlong_after");
    m_ready = 1'b0;
    send(8'h01);
    check_out("overlong_next", 80'h01, 4'd1, 1'b0);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;

    // Backpressure: outputs stay stable while m_ready is low.
    send(8'h80);
    send(8'h7F);
    for (int i = 0; i < 5; i++) begin
      check_out("bp", 80'h7F80, 4'd2, 1'b0);
      check("bp_s_ready", 80'(s_ready), 80'h0);
      tick();
    end
    m_ready = 1'b1;
    tick();
    check_idle("bp_after");
    m_ready = 1'b0;

    // Flush mid-value, with a byte offered in the same cycle that must be dropped.
    send(8'h80);
    send(8'h80);
    flush = 1'b1; s_valid = 1'b1; s_data = 8'h05;
    #1;
    check("flush_s_ready", 80'(s_ready), 80'h0);
    tick();
    flush = 1'b0; s_valid = 1'b0;
    check_idle("flush");
    send(8'h05);
    check_out("flush_next", 80'h05, 4'd1, 1'b0);
    // Flush a held value.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_idle("flush_hold");

    // Reset mid-value.
    send(8'h80);
    send(8'h80);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("rst_mid");
    send(8'h05);
    check_out("rst_next", 80'h05, 4'd1, 1'b0);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;

`ifdef LEB128_COLLECT_BYPASS_EN
    // Back-to-back single-byte values with no bubble.
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h01;
    tick();
    check_out("byp1", 80'h01, 4'd1, 1'b0);
    check("byp1_s_ready", 80'(s_ready), 80'h1);
    s_data = 8'h02;
    tick();
    check_out("byp2", 80'h02, 4'd1, 1'b0);
    check("byp2_s_ready", 80'(s_ready), 80'h1);
    s_data = 8'h03;
    tick();
    check_out("byp3", 80'h03, 4'd1, 1'b0);
    s_valid = 1'b0;
    tick();
    check_idle("byp_after");
    m_ready = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/leb128_byte_collector.md
Name: leb128_byte_collector

Overview:
Upstream framing stage for the parallel LEB128 decoders (unpack_u64 / unpack_i64).
- Accepts a serial byte stream with a valid/ready handshake.
- Collects the bytes of one LEB128 value until a byte with bit 7 = 0 arrives or MAX_BYTES bytes have been taken.
- Presents the collected bytes as a zero-padded parallel word, with length and overlong-error flags, on a second valid/ready handshake.
- Output bytes map directly onto decoder inputs i0..i9.

Parameters:
MAX_BYTES, 10, maximum encoded length in bytes; legal range 1..10; the output bus is 80 bits regardless.

Ports:
clk      input   1   clock; all state updates on rising edge
rst      input   1   synchronous, active-high reset
flush    input   1   synchronous drop of any partial or held value
s_data   input   8   incoming LEB128 byte
s_valid  input   1   s_data valid
s_ready  output  1   collector can accept s_data this cycle
m_bytes  output  80  collected bytes; byte k at [8k+7:8k] (byte 0 = first received); unused slots 0x00
m_len    output  4   number of bytes in value, 1..MAX_BYTES
m_err    output  1   overlong: MAX_BYTES bytes taken and the last one still had bit 7 = 1
m_valid  output  1   m_bytes/m_len/m_err hold a complete value
m_ready  input   1   downstream consumes value this cycle

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high. The reset values below apply on the first rising edge with rst=1.
- Reset values: state=COLLECT, cnt=0, m_bytes=0, m_len=0, m_err=0, m_valid=0; s_ready=1 after reset is released.
- Input handshake: a byte is accepted when s_valid & s_ready. An output transfer occurs when m_valid & m_ready.
- Priority: rst > flush > handshakes.
- State COLLECT:
  - s_ready=1, m_valid=0.
  - On an accepted byte: slot cnt ← s_data.
  - If s_data[7]=0, or cnt=MAX_BYTES-1: go to HOLD; m_len ← cnt+1; m_err ← s_data[7]; cnt ← 0.
  - Otherwise cnt ← cnt+1.
- State HOLD:
  - m_valid=1; s_ready=0 (see the optional feature).
  - m_bytes, m_len and m_err are registered and stay stable while m_valid=1 and m_ready=0.
  - On an output transfer: all slots ← 0x00, m_len ← 0, m_err ← 0, state ← COLLECT. The earliest next byte is accepted on the following cycle.
- Latency: m_valid rises on the cycle after the terminating byte is accepted (one register stage).
- Idle input: s_valid=0 mid-value leaves the partial bytes and cnt untouched indefinitely.
- flush=1 in any state: all slots cleared, cnt=0, m_len=0, m_err=0, m_valid=0, state=COLLECT. Any byte presented in the same cycle is not accepted (s_ready is forced 0 while flush=1).
- Overlong value: the MAX_BYTES-th byte always terminates the value. Bytes after it are treated as the start of the next value; no resynchronisation is attempted.
- cnt never exceeds MAX_BYTES-1, and slots at or above MAX_BYTES always read 0x00.
- m_bytes is zero-padded, so the decoder's used-byte logic (driven by glue bits) sees a clean high end.
- rst in the middle of a value or while holding one discards it with no output transfer.

Optional Feature:
Macro LEB128_COLLECT_BYPASS_EN.
- Defined:
  - In HOLD, s_ready = m_ready.
  - On a simultaneous output transfer and byte accept, the held value is released. The new byte is written into slot 0 with all other slots cleared.
  - If that byte has bit 7 = 0, the block stays in HOLD with m_len=1; otherwise it goes to COLLECT with cnt=1.
  - Sustained throughput is one single-byte value per cycle.
- Not defined:
  - s_ready=0 throughout HOLD.
  - One bubble cycle separates consecutive values.

Test Plan:
- Single byte: send 0x02 with m_ready=1 → m_valid for one cycle; m_bytes[7:0]=0x02, upper bytes 0; m_len=1; m_err=0.
- Multi-byte: send 0xE5, 0x8E, 0x26 → m_bytes[23:0]=0x268EE5; m_len=3; m_err=0; s_ready=0 during HOLD (bypass off).
- Overlong: send ten bytes of 0xFF → m_len=10, m_err=1, all 80 bits = 0xFF. A following byte 0x01 → next value with m_len=1.
- Backpressure: send 0x80, 0x7F with m_ready=0 for 5 cycles → outputs stable at m_bytes[15:0]=0x7F80, m_len=2, s_ready=0. Raise m_ready → transfer, then m_bytes=0.
- Flush/reset mid-value: send 0x80, 0x80, then flush=1 (repeat the sequence using rst=1) → m_valid=0, next 0x05 yields m_len=1, m_bytes[7:0]=0x05.
- Bypass (macro defined): stream 0x01, 0x02, 0x03 back-to-back with m_ready=1 → three consecutive m_valid cycles with values 0x01, 0x02, 0x03; s_ready stays 1.
